// File: rtl/router_pkt_tx.sv
// Source-side packet transmitter for the router input port: buffers a whole payload,
// then sends header, payload and parity, honouring busy and reporting router errors.
module router_pkt_tx #(
    parameter int MAX_LEN  = 63,
    parameter int ERR_WAIT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_vld,
    output logic       cmd_rdy,
    input  logic [1:0] cmd_addr,
    input  logic [5:0] cmd_len,
    input  logic       pl_vld,
    output logic       pl_rdy,
    input  logic [7:0] pl_data,
    output logic [7:0] d_in,
    output logic       pkt_vld,
    input  logic       busy,
    input  logic       error,
    output logic       tx_active,
    output logic       done,
    output logic       done_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HDR,
        S_PAY,
        S_PAR,
        S_ERRW,
        S_DONE
    } state_t;

    localparam int             IW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [5:0]     LEN_MAX = 6'(MAX_LEN);
    localparam int             WW      = $clog2(ERR_WAIT + 1) + 1;
    localparam logic [WW-1:0]  W_LAST  = WW'(ERR_WAIT);

    state_t          state, state_nx;
    logic [5:0]      len_q, len_nx;
    logic [1:0]      addr_q, addr_nx;
    logic [5:0]      idx, idx_nx;
    logic [7:0]      parity, parity_nx;
    logic            err, err_nx;
    logic [WW-1:0]   wcnt, wcnt_nx;
    logic            wr_en;
    logic [7:0]      mem [0:MAX_LEN-1];

    logic            cmd_rdy_nx, pl_rdy_nx, pkt_vld_nx, tx_active_nx, done_nx, done_err_nx;
    logic [7:0]      d_in_nx;

    // Next-state logic. In HDR/PAY/PAR the byte on d_in is consumed whenever busy is low.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_nx  = state;
        len_nx    = len_q;
        addr_nx   = addr_q;
        idx_nx    = idx;
        parity_nx = parity;
        err_nx    = err;
        wcnt_nx   = wcnt;
        wr_en     = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_vld && cmd_rdy) begin
                    len_nx  = cmd_len;
                    addr_nx = cmd_addr;
                    idx_nx  = 6'd0;
                    err_nx  = 1'b0;
                    wcnt_nx = '0;
                    if (cmd_len > LEN_MAX) begin
                        state_nx = S_DONE;
                        err_nx   = 1'b1;
                    end else if (cmd_len == 6'd0) begin
                        state_nx = S_HDR;
                    end else begin
                        state_nx = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (pl_vld && pl_rdy) begin
                    wr_en = 1'b1;
                    if (idx == len_q - 6'd1) begin
                        idx_nx   = 6'd0;
                        state_nx = S_HDR;
                    end else begin
                        idx_nx = idx + 6'd1;
                    end
                end
            end
            S_HDR: begin
                if (!busy) begin
                    parity_nx = {len_q, addr_q};
                    state_nx  = (len_q == 6'd0) ? S_PAR : S_PAY;
                end
            end
            S_PAY: begin
                if (!busy) begin
                    parity_nx = parity ^ d_in;
                    if (idx == len_q - 6'd1) begin
                        state_nx = S_PAR;
                    end else begin
                        idx_nx = idx + 6'd1;
                    end
                end
            end
            S_PAR: begin
                if (!busy) begin
                    state_nx = S_ERRW;
                    wcnt_nx  = '0;
                end
            end
            S_ERRW: begin
                // wcnt runs 0..ERR_WAIT, so done lands N+3+ERR_WAIT cycles after the header
                err_nx = err | error;
                if (wcnt == W_LAST) begin
                    state_nx = S_DONE;
                end else begin
                    wcnt_nx = wcnt + 1'b1;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it.
    always_comb begin
        cmd_rdy_nx   = 1'b0;
        pl_rdy_nx    = 1'b0;
        d_in_nx      = 8'h00;
        pkt_vld_nx   = 1'b0;
        tx_active_nx = 1'b1;
        done_nx      = 1'b0;
        done_err_nx  = 1'b0;
        case (state_nx)
            S_IDLE: begin
                cmd_rdy_nx   = 1'b1;
                tx_active_nx = 1'b0;
            end
            S_LOAD: pl_rdy_nx = 1'b1;
            S_HDR: begin
                d_in_nx    = {len_nx, addr_nx};
                pkt_vld_nx = 1'b1;
            end
            S_PAY: begin
                d_in_nx    = mem[idx_nx[IW-1:0]];
                pkt_vld_nx = 1'b1;
            end
            S_PAR:  d_in_nx = parity_nx;
            S_DONE: begin
                done_nx     = 1'b1;
                done_err_nx = err_nx;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state     <= S_IDLE;
            len_q     <= 6'd0;
            addr_q    <= 2'd0;
            idx       <= 6'd0;
            parity    <= 8'h00;
            err       <= 1'b0;
            wcnt      <= '0;
            cmd_rdy   <= 1'b0;
            pl_rdy    <= 1'b0;
            d_in      <= 8'h00;
            pkt_vld   <= 1'b0;
            tx_active <= 1'b0;
            done      <= 1'b0;
            done_err  <= 1'b0;
        end else begin
            state     <= state_nx;
            len_q     <= len_nx;
            addr_q    <= addr_nx;
            idx       <= idx_nx;
            parity    <= parity_nx;
            err       <= err_nx;
            wcnt      <= wcnt_nx;
            cmd_rdy   <= cmd_rdy_nx;
            pl_rdy    <= pl_rdy_nx;
            d_in      <= d_in_nx;
            pkt_vld   <= pkt_vld_nx;
            tx_active <= tx_active_nx;
            done      <= done_nx;
            done_err  <= done_err_nx;
        end
    end

    // NOTE: the payload buffer is not reset; every byte is written in LOAD before it is read.
    always_ff @(posedge clk) begin
        if (wr_en) mem[idx[IW-1:0]] <= pl_data;
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: stream order, busy stalls, parity, error window,
// oversize rejection and mid-packet reset.
module tb_router_pkt_tx;

    localparam int W = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_vld = 1'b0, cmd_vld_s = 1'b0;
    logic [1:0] cmd_addr = 2'd0;
    logic [5:0] cmd_len = 6'd0;
    logic       pl_vld = 1'b0;
    logic [7:0] pl_data = 8'h00;
    logic       busy = 1'b0, error = 1'b0;

    logic       cmd_rdy, pl_rdy, pkt_vld, tx_active, done, done_err;
    logic [7:0] d_in;
    logic       cmd_rdy_s, pl_rdy_s, pkt_vld_s, tx_active_s, done_s, done_err_s;
    logic [7:0] d_in_s;

    int checks = 0, failures = 0;
    int cyc = 0, done_cnt = 0, plrdy_cnt = 0;
    logic [7:0] pl [0:63];

    router_pkt_tx #(.MAX_LEN(63), .ERR_WAIT(W)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .pl_vld(pl_vld), .pl_rdy(pl_rdy),
        .pl_data(pl_data), .d_in(d_in), .pkt_vld(pkt_vld), .busy(busy), .error(error),
        .tx_active(tx_active), .done(done), .done_err(done_err)
    );

    router_pkt_tx #(.MAX_LEN(16), .ERR_WAIT(W)) u_small (
        .clk(clk), .rst_n(rst_n), .cmd_vld(cmd_vld_s), .cmd_rdy(cmd_rdy_s),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .pl_vld(pl_vld), .pl_rdy(pl_rdy_s),
        .pl_data(pl_data), .d_in(d_in_s), .pkt_vld(pkt_vld_s), .busy(busy), .error(error),
        .tx_active(tx_active_s), .done(done_s), .done_err(done_err_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (pl_rdy === 1'b1) plrdy_cnt <= plrdy_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Full packet: command, payload load, transmit with optional stall, error window, done.
    // abort_k >= 0 pulls rst_n low while stream byte abort_k is on d_in and returns.
    task automatic run_pkt(input string tag, input logic [1:0] addr, input int len,
                           input int busy_k, input int busy_n, input bit err_early,
                           input bit err_pulse, input int abort_k);
        logic [7:0] exp_b [0:64];
        logic [7:0] par;
        int acc_c, hdr_c, k, held, g, stall;
        exp_b[0] = {len[5:0], addr};
        par = exp_b[0];
        for (int i = 0; i < len; i++) begin
            exp_b[i+1] = pl[i];
            par ^= pl[i];
        end
        stall = (busy_k >= 0) ? busy_n : 0;

        @(negedge clk);
        check({tag, " cmd_rdy idle"}, cmd_rdy, 1);
        cmd_vld = 1'b1; cmd_addr = addr; cmd_len = len[5:0]; acc_c = cyc;
        @(negedge clk);
        cmd_vld = 1'b0;
        for (int i = 0; i < len; i++) begin
            check($sformatf("%s pl_rdy%0d", tag, i), pl_rdy, 1);
            pl_vld = 1'b1; pl_data = pl[i];
            @(negedge clk);
        end
        // extra payload offered after the last byte must be ignored
        pl_vld = 1'b1; pl_data = 8'hEE;
        hdr_c = cyc;
        check({tag, " pl_rdy after load"}, pl_rdy, 0);
        check({tag, " hdr latency"}, hdr_c - acc_c, len + 1);
        check({tag, " tx_active"}, tx_active, 1);

        k = 0; held = 0; g = 0;
        while (k < len + 2 && g < 300) begin
            if (k == abort_k) begin
                rst_n = 1'b0; pl_vld = 1'b0;
                #1;
                check({tag, " rst pkt_vld"}, pkt_vld, 0);
                check({tag, " rst d_in"}, d_in, 0);
                check({tag, " rst tx_active"}, tx_active, 0);
                repeat (2) @(negedge clk);
                check({tag, " rst done"}, done, 0);
                rst_n = 1'b1;
                return;
            end
            check($sformatf("%s d_in%0d", tag, k), d_in, (k == len + 1) ? par : exp_b[k]);
            check($sformatf("%s pkt_vld%0d", tag, k), pkt_vld, (k <= len) ? 1 : 0);
            busy = (k == busy_k && held < busy_n);
            if (busy) held++;
            else k++;
            error = err_early;
            @(negedge clk);
            g++;
        end
        busy = 1'b0; pl_vld = 1'b0;
        check({tag, " bytes accepted"}, k, len + 2);

        error = err_pulse;
        g = 0;
        while (done !== 1'b1 && g < 50) begin
            @(negedge clk);
            error = 1'b0;
            g++;
        end
        error = 1'b0;
        check({tag, " done"}, done, 1);
        check({tag, " done latency"}, cyc - hdr_c, len + 3 + W + stall);
        check({tag, " done_err"}, done_err, err_pulse);
        @(negedge clk);
        check({tag, " done pulse width"}, done, 0);
        check({tag, " tx_active off"}, tx_active, 0);
        check({tag, " cmd_rdy back"}, cmd_rdy, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, p0;
        // reset state
        repeat (3) @(negedge clk);
        check("rst cmd_rdy", cmd_rdy, 0);
        check("rst pl_rdy", pl_rdy, 0);
        check("rst pkt_vld", pkt_vld, 0);
        check("rst d_in", d_in, 0);
        check("rst tx_active", tx_active, 0);
        check("rst done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("cmd_rdy after release", cmd_rdy, 1);

        // 1: len=4 addr=1, header 0x11
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33; pl[3] = 8'h44;
        run_pkt("t1", 2'd1, 4, -1, 0, 1'b0, 1'b0, -1);

        // 2: same packet, byte 0x22 stalled 3 cycles; error outside ERRW ignored
        run_pkt("t2", 2'd1, 4, 2, 3, 1'b1, 1'b0, -1);

        // 3: empty packet, no payload handshake
        p0 = plrdy_cnt;
        run_pkt("t3", 2'd2, 0, -1, 0, 1'b0, 1'b0, -1);
        check("t3 pl_rdy never", plrdy_cnt - p0, 0);

        // 4: maximum length, addr=3, error pulse in window
        for (int i = 0; i < 63; i++) pl[i] = 8'($urandom);
        run_pkt("t4", 2'd3, 63, 20, 2, 1'b0, 1'b1, -1);

        // 5: oversize command on MAX_LEN=16 instance
        @(negedge clk);
        check("t5 cmd_rdy", cmd_rdy_s, 1);
        cmd_vld_s = 1'b1; cmd_addr = 2'd1; cmd_len = 6'd20;
        @(negedge clk);
        cmd_vld_s = 1'b0;
        check("t5 done", done_s, 1);
        check("t5 done_err", done_err_s, 1);
        check("t5 pkt_vld", pkt_vld_s, 0);
        check("t5 cmd_rdy low", cmd_rdy_s, 0);
        @(negedge clk);
        check("t5 done width", done_s, 0);
        check("t5 cmd_rdy back", cmd_rdy_s, 1);
        check("t5 tx_active", tx_active_s, 0);
        check("t5 pkt_vld after", pkt_vld_s, 0);

        // 6: reset during payload byte 3 of len=10, then a clean len=2 packet
        for (int i = 0; i < 10; i++) pl[i] = 8'(8'h30 + i);
        d0 = done_cnt;
        run_pkt("t6", 2'd0, 10, -1, 0, 1'b0, 1'b0, 4);
        @(negedge clk);
        check("t6 no done", done_cnt - d0, 0);
        pl[0] = 8'hA5; pl[1] = 8'h5A;
        run_pkt("t6b", 2'd2, 2, -1, 0, 1'b0, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
